// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and requester ids for mem_port_arbiter
//
// Imported by the arbiter top and its winner-selection helper.
//   arb_state_t : IDLE / ISSUE / WAIT / RESP sequencing states
//   REQ_IF      : requester id of the instruction-fetch side
//   REQ_D       : requester id of the load/store data side
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of fetch, data and memory-port signals around the arbiter
//
// Ports (slave = arbiter view, master = core/memory environment view):
//   IF_REQ/IF_ADDR          fetch read request and address
//   IF_RDATA/IF_ACK         fetch read data and one-cycle completion
//   D_RREQ/D_WREQ/D_ADDR    data read/write request and address
//   D_WDATA/D_WSTRB         data write payload and byte strobes
//   D_RDATA/D_ACK           data read data and one-cycle completion
//   M_REQ/M_WE/M_ADDR       memory request pulse, direction, address
//   M_WDATA/M_WSTRB         memory write payload and strobes
//   M_RDATA/M_RDY           memory read data and completion
//   BUSY                    arbiter is not idle
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            IF_REQ;
    logic [AW-1:0]   IF_ADDR;
    logic [DW-1:0]   IF_RDATA;
    logic            IF_ACK;

    logic            D_RREQ;
    logic            D_WREQ;
    logic [AW-1:0]   D_ADDR;
    logic [DW-1:0]   D_WDATA;
    logic [DW/8-1:0] D_WSTRB;
    logic [DW-1:0]   D_RDATA;
    logic            D_ACK;

    logic            M_REQ;
    logic            M_WE;
    logic [AW-1:0]   M_ADDR;
    logic [DW-1:0]   M_WDATA;
    logic [DW/8-1:0] M_WSTRB;
    logic [DW-1:0]   M_RDATA;
    logic            M_RDY;

    logic            BUSY;

    modport slave (
        input  IF_REQ, IF_ADDR,
        output IF_RDATA, IF_ACK,
        input  D_RREQ, D_WREQ, D_ADDR, D_WDATA, D_WSTRB,
        output D_RDATA, D_ACK,
        output M_REQ, M_WE, M_ADDR, M_WDATA, M_WSTRB,
        input  M_RDATA, M_RDY,
        output BUSY
    );

    modport master (
        output IF_REQ, IF_ADDR,
        input  IF_RDATA, IF_ACK,
        output D_RREQ, D_WREQ, D_ADDR, D_WDATA, D_WSTRB,
        input  D_RDATA, D_ACK,
        input  M_REQ, M_WE, M_ADDR, M_WDATA, M_WSTRB,
        output M_RDATA, M_RDY,
        input  BUSY
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data requesters
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (adds the last-grant input and
// alternates on ties; otherwise data always wins).
// Ports:
//   if_req  : fetch request pending
//   d_req   : data read or write request pending
//   last    : requester granted most recently (round-robin build only)
//   any_req : at least one request pending
//   winner  : REQ_IF or REQ_D
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last,
`endif
    output logic any_req,
    output logic winner
);

    always_comb begin
        any_req = if_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie the side that did not win last time goes first.
        if (if_req && d_req) begin
            winner = (last == REQ_D) ? REQ_IF : REQ_D;
        end else begin
            winner = d_req ? REQ_D : REQ_IF;
        end
`else
        winner = d_req ? REQ_D : REQ_IF;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break with a
// one-bit last-grant pointer; undefined = fixed priority, data over fetch).
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-low reset
//   bus : mem_port_arbiter_if.slave carrying the fetch, data and memory signals
// Sequence per transaction: IDLE (grant + latch) -> ISSUE (M_REQ pulse) ->
// WAIT (until M_RDY) -> RESP (ACK pulse) -> IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic                 CLK,
    input  logic                 RST,
    mem_port_arbiter_if.slave    bus
);

    arb_state_t      state;
    logic            win_q;

    logic            m_req_q;
    logic            m_we_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_wdata_q;
    logic [DW/8-1:0] m_wstrb_q;
    logic [DW-1:0]   if_rdata_q;
    logic [DW-1:0]   d_rdata_q;
    logic            if_ack_q;
    logic            d_ack_q;
    logic            busy_q;

    logic            d_req;
    logic            any_req;
    logic            pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic            last_q;
`endif

    assign d_req = bus.D_RREQ | bus.D_WREQ;

    mem_arb_pick u_pick (
        .if_req  (bus.IF_REQ),
        .d_req   (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last    (last_q),
`endif
        .any_req (any_req),
        .winner  (pick)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            win_q      <= REQ_IF;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Fetch counts as last served so data wins the first tie.
            last_q     <= REQ_IF;
`endif
        end else begin
            // Pulses default low; each state raises only what it owns.
            m_req_q  <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= ISSUE;
                        win_q   <= pick;
                        m_req_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_q  <= pick;
`endif
                        if (pick == REQ_D) begin
                            // Read+write together is treated as a write.
                            m_we_q    <= bus.D_WREQ;
                            m_addr_q  <= bus.D_ADDR;
                            m_wdata_q <= bus.D_WDATA;
                            m_wstrb_q <= bus.D_WSTRB;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_addr_q  <= bus.IF_ADDR;
                            m_wdata_q <= '0;
                            m_wstrb_q <= '0;
                        end
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (bus.M_RDY) begin
                        state <= RESP;
                        if (win_q == REQ_D) begin
                            d_ack_q <= 1'b1;
                            if (!m_we_q) begin
                                d_rdata_q <= bus.M_RDATA;
                            end
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.M_RDATA;
                        end
                    end
                end

                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.M_REQ    = m_req_q;
    assign bus.M_WE     = m_we_q;
    assign bus.M_ADDR   = m_addr_q;
    assign bus.M_WDATA  = m_wdata_q;
    assign bus.M_WSTRB  = m_wstrb_q;
    assign bus.IF_RDATA = if_rdata_q;
    assign bus.IF_ACK   = if_ack_q;
    assign bus.D_RDATA  = d_rdata_q;
    assign bus.D_ACK    = d_ack_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference state at transaction level.
    bit          last_d;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_d_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Grant rule: data wins unless round-robin and data was served last on a tie.
    function automatic bit model_pick_d(input bit ifr, input bit dreq, input bit last_was_d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (ifr && dreq) return !last_was_d;
        return dreq;
`else
        return dreq;
`endif
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, ".m_req"},    bus.M_REQ,    1'b0);
        chk({tag, ".m_we"},     bus.M_WE,     1'b0);
        chk({tag, ".m_addr"},   bus.M_ADDR,   32'h0);
        chk({tag, ".m_wdata"},  bus.M_WDATA,  32'h0);
        chk({tag, ".m_wstrb"},  bus.M_WSTRB,  4'h0);
        chk({tag, ".if_ack"},   bus.IF_ACK,   1'b0);
        chk({tag, ".d_ack"},    bus.D_ACK,    1'b0);
        chk({tag, ".if_rdata"}, bus.IF_RDATA, 32'h0);
        chk({tag, ".d_rdata"},  bus.D_RDATA,  32'h0);
        chk({tag, ".busy"},     bus.BUSY,     1'b0);
    endtask

    // Entered at a falling edge in IDLE with requests already driven; returns at
    // the falling edge of the IDLE cycle that follows RESP.
    task automatic do_txn(input int delay, input bit spur, input logic [31:0] rd,
                          input string tag, output bit got_d);
        bit          ifr, dreq, dw, win_d, we;
        logic [31:0] a, wd;
        logic [3:0]  st;
        ifr   = bus.IF_REQ;
        dreq  = bus.D_RREQ | bus.D_WREQ;
        dw    = bus.D_WREQ;
        win_d = model_pick_d(ifr, dreq, last_d);
        last_d = win_d;
        we    = win_d & dw;
        a     = win_d ? bus.D_ADDR : bus.IF_ADDR;
        wd    = bus.D_WDATA;
        st    = bus.D_WSTRB;

        @(negedge CLK);
        chk({tag, ".issue.m_req"}, bus.M_REQ, 1'b1);
        chk({tag, ".issue.m_we"},  bus.M_WE,  we);
        chk({tag, ".issue.addr"},  bus.M_ADDR, a);
        if (we) begin
            chk({tag, ".issue.wdata"}, bus.M_WDATA, wd);
            chk({tag, ".issue.wstrb"}, bus.M_WSTRB, st);
        end
        chk({tag, ".issue.busy"}, bus.BUSY, 1'b1);
        chk({tag, ".issue.acks"}, {bus.IF_ACK, bus.D_ACK}, 2'b00);
        // Inputs other than the request levels may move freely after grant.
        bus.IF_ADDR = $urandom;
        bus.D_ADDR  = $urandom;
        bus.D_WDATA = $urandom;
        bus.D_WSTRB = 4'($urandom);
        if (spur) begin
            bus.M_RDY   = 1'b1;
            bus.M_RDATA = $urandom;
        end

        @(negedge CLK);
        chk({tag, ".wait.m_req"}, bus.M_REQ, 1'b0);
        chk({tag, ".wait.busy"},  bus.BUSY,  1'b1);
        chk({tag, ".wait.acks"},  {bus.IF_ACK, bus.D_ACK}, 2'b00);
        for (int i = 0; i < delay; i++) begin
            bus.M_RDY = 1'b0;
            @(negedge CLK);
            chk({tag, ".wait.hold_acks"}, {bus.IF_ACK, bus.D_ACK}, 2'b00);
            chk({tag, ".wait.hold_addr"}, bus.M_ADDR, a);
            chk({tag, ".wait.hold_busy"}, bus.BUSY, 1'b1);
        end
        bus.M_RDY   = 1'b1;
        bus.M_RDATA = rd;

        @(negedge CLK);
        bus.M_RDY = 1'b0;
        if (!we) begin
            if (win_d) exp_d_rd = rd;
            else       exp_if_rd = rd;
        end
        got_d = bus.D_ACK;
        chk({tag, ".resp.if_ack"},   bus.IF_ACK, !win_d);
        chk({tag, ".resp.d_ack"},    bus.D_ACK,  win_d);
        chk({tag, ".resp.if_rdata"}, bus.IF_RDATA, exp_if_rd);
        chk({tag, ".resp.d_rdata"},  bus.D_RDATA,  exp_d_rd);
        chk({tag, ".resp.busy"},     bus.BUSY, 1'b1);
        chk({tag, ".resp.addr"},     bus.M_ADDR, a);
        if (win_d) begin
            bus.D_RREQ = 1'b0;
            bus.D_WREQ = 1'b0;
        end else begin
            bus.IF_REQ = 1'b0;
        end

        @(negedge CLK);
        chk({tag, ".idle.acks"},     {bus.IF_ACK, bus.D_ACK}, 2'b00);
        chk({tag, ".idle.busy"},     bus.BUSY, 1'b0);
        chk({tag, ".idle.m_req"},    bus.M_REQ, 1'b0);
        chk({tag, ".idle.if_rdata"}, bus.IF_RDATA, exp_if_rd);
        chk({tag, ".idle.d_rdata"},  bus.D_RDATA,  exp_d_rd);
    endtask

    task automatic drain(input string tag);
        bit d;
        for (int k = 0; k < 4 && (bus.IF_REQ || bus.D_RREQ || bus.D_WREQ); k++) begin
            do_txn($urandom_range(0, 3), 1'b0, $urandom, tag, d);
        end
    endtask

    task automatic contend(input string tag);
        bit d;
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 32'h0000_0400;
        bus.D_RREQ  = 1'b1;
        bus.D_ADDR  = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 1'b0, 32'hA000_0000 + 32'(i), tag, d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk({tag, ".grant_d"}, d, (i % 2) == 0);
`else
            chk({tag, ".grant_d"}, d, 1'b1);
`endif
            bus.IF_REQ = 1'b1;
            bus.D_RREQ = 1'b1;
        end
        bus.IF_REQ = 1'b0;
        bus.D_RREQ = 1'b0;
        @(negedge CLK);
        // A request granted at that last edge still has to finish.
        if (bus.BUSY) begin
            repeat (2) @(negedge CLK);
            bus.M_RDY = 1'b1;
            @(negedge CLK);
            bus.M_RDY = 1'b0;
            last_d = !last_d;
            if (last_d) exp_d_rd = 32'hA000_0004;
            else        exp_if_rd = 32'hA000_0004;
            bus.M_RDATA = 32'hA000_0004;
            @(negedge CLK);
        end
    endtask

    initial begin
        bit d;
        int k;
        bus.IF_REQ  = 1'b0;
        bus.IF_ADDR = '0;
        bus.D_RREQ  = 1'b0;
        bus.D_WREQ  = 1'b0;
        bus.D_ADDR  = '0;
        bus.D_WDATA = '0;
        bus.D_WSTRB = '0;
        bus.M_RDATA = '0;
        bus.M_RDY   = 1'b0;
        last_d    = 1'b0;
        exp_if_rd = '0;
        exp_d_rd  = '0;

        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_zero("reset");
        RST = 1'b1;
        @(negedge CLK);

        // Contention right after reset: data takes the first tie.
        bus.IF_REQ = 1'b1;
        bus.D_RREQ = 1'b1;
        bus.IF_ADDR = 32'h0000_0500;
        bus.D_ADDR  = 32'h0000_3100;
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 1'b0, 32'hB000_0000 + 32'(i), "contend", d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("contend.grant_d", d, (i % 2) == 0);
`else
            chk("contend.grant_d", d, 1'b1);
`endif
            bus.IF_REQ = 1'b1;
            bus.D_RREQ = 1'b1;
        end
        bus.D_RREQ = 1'b0;
        drain("contend_drain");

        // Fetch only, minimum latency.
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 32'h0000_0100;
        do_txn(0, 1'b0, 32'hDEAD_BEEF, "fetch", d);
        chk("fetch.if_rdata", bus.IF_RDATA, 32'hDEAD_BEEF);

        // Data write with a slow memory.
        bus.D_WREQ  = 1'b1;
        bus.D_ADDR  = 32'h0000_2000;
        bus.D_WDATA = 32'h1234_5678;
        bus.D_WSTRB = 4'hF;
        do_txn(5, 1'b0, 32'h0BAD_0BAD, "write", d);
        chk("write.d_rdata_kept", bus.D_RDATA, exp_d_rd);

        // Read and write together: one write, one ack.
        bus.D_RREQ  = 1'b1;
        bus.D_WREQ  = 1'b1;
        bus.D_ADDR  = 32'h0000_2040;
        bus.D_WDATA = 32'h5555_AAAA;
        bus.D_WSTRB = 4'h3;
        do_txn(1, 1'b1, 32'h7777_7777, "both", d);

        // Randomized traffic with stray M_RDY in ISSUE and IDLE.
        for (int n = 0; n < 60; n++) begin
            if (!bus.IF_REQ && $urandom_range(0, 1) == 1) begin
                bus.IF_REQ  = 1'b1;
                bus.IF_ADDR = $urandom;
            end
            if (!(bus.D_RREQ || bus.D_WREQ)) begin
                k = $urandom_range(0, 7);
                bus.D_RREQ  = (k == 3 || k == 4 || k == 7);
                bus.D_WREQ  = (k == 5 || k == 6 || k == 7);
                bus.D_ADDR  = $urandom;
                bus.D_WDATA = $urandom;
                bus.D_WSTRB = 4'($urandom);
            end
            if (bus.IF_REQ || bus.D_RREQ || bus.D_WREQ) begin
                do_txn($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom, "rand", d);
            end else begin
                bus.M_RDY   = 1'b1;
                bus.M_RDATA = $urandom;
                @(negedge CLK);
                bus.M_RDY = 1'b0;
                chk("idle_rdy.acks",  {bus.IF_ACK, bus.D_ACK}, 2'b00);
                chk("idle_rdy.busy",  bus.BUSY, 1'b0);
                chk("idle_rdy.m_req", bus.M_REQ, 1'b0);
                chk("idle_rdy.if_rdata", bus.IF_RDATA, exp_if_rd);
            end
        end
        drain("rand_drain");
        bus.IF_REQ = 1'b0;
        bus.D_RREQ = 1'b0;
        bus.D_WREQ = 1'b0;
        @(negedge CLK);

        // Reset in the middle of WAIT, then a late M_RDY.
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 32'h0000_0300;
        @(negedge CLK);
        chk("rst_wait.issue", bus.M_REQ, 1'b1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        bus.IF_REQ  = 1'b0;
        bus.M_RDY   = 1'b1;
        bus.M_RDATA = 32'hFFFF_0000;
        check_zero("rst_wait");
        @(negedge CLK);
        bus.M_RDY = 1'b0;
        check_zero("rst_late_rdy");
        last_d    = 1'b0;
        exp_if_rd = '0;
        exp_d_rd  = '0;

        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 32'h0000_0600;
        do_txn(1, 1'b0, 32'h55AA_33CC, "after_rst", d);
        chk("after_rst.grant_if", d, 1'b0);

        // Pointer was reset as well: contention again starts with data.
        contend("contend2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
